fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core. It replaces the fixed two-source, two-stage combinational forwarding mux-select logic with a unit that tracks in-flight destinations itself. It supports N source operands, a configurable number of forwarding stages and a configurable load-data stage. It computes forwarding selects in ID, registers them so they are valid while the consumer is in EX, and raises the load-use stall.

---
 rtl/fwd_hazard_unit.sv | 114 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard unit that tracks in-flight destinations per stage.
// Optional FWD_PERF_CNT_EN adds stall_cnt / fwd_cnt performance counters.
module fwd_hazard_unit #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LOAD_STAGE = 2,
  localparam int unsigned SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [5*NUM_SRC-1:0]     id_rs_add,
  input  logic [NUM_SRC-1:0]       id_rs_used,
  input  logic [4:0]               id_rd_add,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  output logic                     hazard_stall,
  output logic [SEL_W*NUM_SRC-1:0] ex_fwd_sel,
  output logic                     ex_valid
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              fwd_cnt
`endif
);

  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0]         r_wr;
  logic [DEPTH-1:0]         r_ld;
  logic [4:0]               r_rd [DEPTH];
  logic [SEL_W*NUM_SRC-1:0] r_sel;

  logic [DEPTH-1:0]         w_prod;
  logic [SEL_W*NUM_SRC-1:0] w_sel;
  logic                     w_load_hit;
  logic                     w_take;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_prod[j] = r_vld[j] & r_wr[j] & (r_rd[j] != 5'd0);
    end
  end

  // Scan oldest to youngest so the nearest producer overwrites any older match.
  always_comb begin
    w_sel      = '0;
    w_load_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (id_rs_used[i] && w_prod[j] && (r_rd[j] == id_rs_add[5*i +: 5])) begin
          w_sel[SEL_W*i +: SEL_W] = SEL_W'(j + 1);
          if (r_ld[j] && ((j + 1) < int'(LOAD_STAGE))) begin
            w_load_hit = 1'b1;
          end
        end
      end
    end
  end

  assign hazard_stall = id_valid & ~flush & ~hold & w_load_hit;
  assign w_take       = id_valid & ~hazard_stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_wr  <= '0;
      r_ld  <= '0;
      r_sel <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        r_rd[j] <= 5'd0;
      end
    end else if (!hold) begin
      for (int j = DEPTH - 1; j >= 1; j--) begin
        r_vld[j] <= r_vld[j-1];
        r_wr[j]  <= r_wr[j-1];
        r_ld[j]  <= r_ld[j-1];
        r_rd[j]  <= r_rd[j-1];
      end
      r_vld[0] <= w_take;
      r_wr[0]  <= id_reg_write;
      r_ld[0]  <= id_mem_read;
      r_rd[0]  <= id_rd_add;
      r_sel    <= w_take ? w_sel : '0;
    end
  end

  assign ex_valid   = r_vld[0];
  assign ex_fwd_sel = r_sel;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
      r_fwd_cnt   <= 32'd0;
    end else if (!hold) begin
      if (hazard_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (r_vld[0] && (r_sel != '0)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized bench for fwd_hazard_unit: default (2/2) and deep (3/3) instances vs. a history model.
module tb_fwd_hazard_unit;

  localparam int NS  = 2;
  localparam int D0  = 2;
  localparam int L0  = 2;
  localparam int D1  = 3;
  localparam int L1  = 3;
  localparam int SW0 = $clog2(D0 + 1);
  localparam int SW1 = $clog2(D1 + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            hold;
  logic            flush;
  logic            id_valid;
  logic [5*NS-1:0] id_rs_add;
  logic [NS-1:0]   id_rs_used;
  logic [4:0]      id_rd_add;
  logic            id_reg_write;
  logic            id_mem_read;

  logic            st0, st1, exv0, exv1;
  logic [SW0*NS-1:0] sel0;
  logic [SW1*NS-1:0] sel1;
`ifdef FWD_PERF_CNT_EN
  logic [31:0] sc0, fc0, sc1, fc1;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NUM_SRC(NS), .DEPTH(D0), .LOAD_STAGE(L0)) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_rs_add    (id_rs_add),
    .id_rs_used   (id_rs_used),
    .id_rd_add    (id_rd_add),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .hazard_stall (st0),
    .ex_fwd_sel   (sel0),
    .ex_valid     (exv0)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt    (sc0),
    .fwd_cnt      (fc0)
`endif
  );

  fwd_hazard_unit #(.NUM_SRC(NS), .DEPTH(D1), .LOAD_STAGE(L1)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_rs_add    (id_rs_add),
    .id_rs_used   (id_rs_used),
    .id_rd_add    (id_rd_add),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .hazard_stall (st1),
    .ex_fwd_sel   (sel1),
    .ex_valid     (exv1)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt    (sc1),
    .fwd_cnt      (fc1)
`endif
  );

  // Issued-slot history per instance: age 0 is the instruction now in EX.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } slot_t;

  slot_t hist [2][8];
  int    m_sel [2][NS];
  int    m_sc  [2];
  int    m_fc  [2];
  int    errors = 0;
  int    checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic bit produces(slot_t s, bit [4:0] rs);
    return s.v && s.wr && (s.rd != 5'd0) && (s.rd == rs);
  endfunction

  // Nearest producer of source i; it reaches stage (age+1) when the consumer enters EX.
  function automatic int exp_sel(int n, int d, int i);
    bit [4:0] rs;
    rs = id_rs_add[5*i +: 5];
    if (!id_rs_used[i]) return 0;
    for (int k = 0; k < d; k++) begin
      if (produces(hist[n][k], rs)) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit exp_stall(int n, int d, int ls);
    if (!id_valid || flush || hold) return 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (id_rs_used[i]) begin
        for (int k = 0; k < d; k++) begin
          if (produces(hist[n][k], id_rs_add[5*i +: 5]) && hist[n][k].ld && (k + 1 < ls))
            return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 8; k++) hist[n][k] = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
      for (int i = 0; i < NS; i++) m_sel[n][i] = 0;
      m_sc[n] = 0;
      m_fc[n] = 0;
    end
  endtask

  task automatic model_step(int n, int d, bit stall);
    bit take;
    bit any;
    int nsel [NS];
    if (rst) begin
      for (int k = 0; k < 8; k++) hist[n][k] = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
      for (int i = 0; i < NS; i++) m_sel[n][i] = 0;
      m_sc[n] = 0;
      m_fc[n] = 0;
    end else if (!hold) begin
      take = id_valid && !stall && !flush;
      any  = 1'b0;
      for (int i = 0; i < NS; i++) if (m_sel[n][i] != 0) any = 1'b1;
      if (stall) m_sc[n]++;
      if (hist[n][0].v && any) m_fc[n]++;
      for (int i = 0; i < NS; i++) nsel[i] = take ? exp_sel(n, d, i) : 0;
      for (int k = d - 1; k >= 1; k--) hist[n][k] = hist[n][k-1];
      hist[n][0] = '{v: take, rd: id_rd_add, wr: id_reg_write, ld: id_mem_read};
      for (int i = 0; i < NS; i++) m_sel[n][i] = nsel[i];
    end
  endtask

  initial begin
    bit es0, es1;
    rst          = 1'b1;
    hold         = 1'b0;
    flush        = 1'b0;
    id_valid     = 1'b0;
    id_rs_add    = '0;
    id_rs_used   = '0;
    id_rd_add    = '0;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    model_reset();
    @(posedge clk);
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      rst          = (cyc < 2) || ($urandom_range(0, 99) < 2);
      hold         = $urandom_range(0, 99) < 10;
      flush        = $urandom_range(0, 99) < 8;
      id_valid     = $urandom_range(0, 99) < 85;
      for (int i = 0; i < NS; i++) id_rs_add[5*i +: 5] = 5'($urandom_range(0, 3));
      id_rs_used   = NS'($urandom);
      id_rd_add    = 5'($urandom_range(0, 3));
      id_reg_write = $urandom_range(0, 99) < 85;
      id_mem_read  = $urandom_range(0, 99) < 35;
      #1;
      es0 = exp_stall(0, D0, L0);
      es1 = exp_stall(1, D1, L1);
      check_val("stall_d2", 32'(st0), 32'(es0));
      check_val("stall_d3", 32'(st1), 32'(es1));
      check_val("ex_valid_d2", 32'(exv0), 32'(hist[0][0].v));
      check_val("ex_valid_d3", 32'(exv1), 32'(hist[1][0].v));
      for (int i = 0; i < NS; i++) begin
        check_val($sformatf("sel_d2_src%0d", i), 32'(sel0[SW0*i +: SW0]), 32'(m_sel[0][i]));
        check_val($sformatf("sel_d3_src%0d", i), 32'(sel1[SW1*i +: SW1]), 32'(m_sel[1][i]));
      end
`ifdef FWD_PERF_CNT_EN
      check_val("stall_cnt_d2", sc0, 32'(m_sc[0]));
      check_val("fwd_cnt_d2", fc0, 32'(m_fc[0]));
      check_val("stall_cnt_d3", sc1, 32'(m_sc[1]));
      check_val("fwd_cnt_d3", fc1, 32'(m_fc[1]));
`endif
      model_step(0, D0, es0);
      model_step(1, D1, es1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
